// File: rtl/multiplier_pkg.sv
// Shared types and constants for the add-shift multiplier control path.
package multiplier_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ADD,
    SHIFT,
    HOLD
  } ctrl_state_t;

  localparam int unsigned MULT_N_BITS = 8;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multiplier_control_fsm_if.sv
// Button inputs, datapath feedback and control strobes between the sequencer and its neighbours.
interface multiplier_control_fsm_if;
  logic Run;
  logic ClearA_LoadB;
  logic M;
  logic LoadB;
  logic Clr_A;
  logic Add;
  logic Sub;
  logic Shift;
  logic Busy;
  logic Done;

  modport master (
    output Run, ClearA_LoadB, M,
    input  LoadB, Clr_A, Add, Sub, Shift, Busy, Done
  );

  modport slave (
    input  Run, ClearA_LoadB, M,
    output LoadB, Clr_A, Add, Sub, Shift, Busy, Done
  );
endinterface

// File: rtl/button_conditioner.sv
// Synchroniser + debouncer for one active-low button; emits the debounced level and a
// one-cycle press pulse on each debounced 1->0 transition.
module button_conditioner
  import multiplier_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 65536
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic level,
  output logic press
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  // Level only moves after the synced input disagrees for DEBOUNCE_CYCLES cycles in a row.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], btn_n};
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (synced != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = synced;
        press_d = level_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '1;
      cnt_q   <= '0;
      level_q <= 1'b1;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/multiplier_control_fsm.sv
// Sequencer for a signed N_BITS x N_BITS add-shift multiply: conditions the Run / ClearA_LoadB
// buttons and drives the per-cycle datapath strobes.
module multiplier_control_fsm
  import multiplier_pkg::*;
#(
  parameter int unsigned N_BITS          = MULT_N_BITS,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 65536
) (
  input  logic                      Clk,
  input  logic                      Reset,
  multiplier_control_fsm_if.slave   bus
);

  localparam int unsigned ITER_W = cnt_width(N_BITS);

  ctrl_state_t       state_q, state_d;
  logic [ITER_W-1:0] iter_q, iter_d;

  logic run_level;
  logic run_press;
  logic loadb_level_unused;
  logic loadb_press;
  logic last_iter;

  logic loadb_c, clr_a_c, add_c, sub_c, shift_c, busy_c, done_c;

  button_conditioner #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_run_cond (
    .clk   (Clk),
    .rst_n (Reset),
    .btn_n (bus.Run),
    .level (run_level),
    .press (run_press)
  );

  button_conditioner #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_loadb_cond (
    .clk   (Clk),
    .rst_n (Reset),
    .btn_n (bus.ClearA_LoadB),
    .level (loadb_level_unused),
    .press (loadb_press)
  );

  assign last_iter = (iter_q == ITER_W'(N_BITS - 1));

  // Next state and strobe decode; Add/Sub follow M combinationally within the ADD cycle.
  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    loadb_c = 1'b0;
    clr_a_c = 1'b0;
    add_c   = 1'b0;
    sub_c   = 1'b0;
    shift_c = 1'b0;
    busy_c  = 1'b0;
    done_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (loadb_press) begin
          loadb_c = 1'b1;
        end else if (run_press) begin
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        clr_a_c = 1'b1;
        busy_c  = 1'b1;
        iter_d  = '0;
        state_d = ADD;
      end
      ADD: begin
        busy_c  = 1'b1;
        add_c   = bus.M;
        sub_c   = bus.M & last_iter;
        state_d = SHIFT;
      end
      SHIFT: begin
        busy_c  = 1'b1;
        shift_c = 1'b1;
        if (last_iter) begin
          state_d = HOLD;
        end else begin
          iter_d  = iter_q + ITER_W'(1);
          state_d = ADD;
        end
      end
      HOLD: begin
        done_c = 1'b1;
        // Holding Run keeps us here, so one press yields exactly one multiply.
        if (run_level) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
    end
  end

  assign bus.LoadB = loadb_c;
  assign bus.Clr_A = clr_a_c;
  assign bus.Add   = add_c;
  assign bus.Sub   = sub_c;
  assign bus.Shift = shift_c;
  assign bus.Busy  = busy_c;
  assign bus.Done  = done_c;

endmodule

// File: tb/tb_multiplier_control_fsm.sv
// Directed bench for multiplier_control_fsm with a 4-cycle debounce and 8-bit multiplier.
module tb_multiplier_control_fsm;
  import multiplier_pkg::*;

  logic Clk = 1'b0;
  logic Reset;

  always #5 Clk = ~Clk;

  multiplier_control_fsm_if bus ();

  multiplier_control_fsm #(
    .N_BITS          (8),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  wire [6:0] outs = {bus.LoadB, bus.Clr_A, bus.Add, bus.Sub, bus.Shift, bus.Busy, bus.Done};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic hit(input int sel);
    case (sel)
      0:       return bus.Clr_A;
      1:       return bus.LoadB;
      default: return !bus.Done;
    endcase
  endfunction

  // Counts cycles until the selected event, bounded so a dead DUT cannot hang the run.
  task automatic wait_for(input string tag, input int sel, input int exp_lat);
    int n = 0;
    while (!hit(sel) && n < 40) begin
      tick();
      n++;
    end
    chk(tag, n, exp_lat);
  endtask

  // Entered on the CLEAR cycle; M presents the multiplier bit b[i] for iteration i.
  task automatic do_mult(input logic [7:0] b, input string tg);
    logic [5:0] e;
    chk({tg, "_clear"}, {bus.Clr_A, bus.Busy, bus.Add, bus.Shift}, 4'b1100);
    for (int i = 0; i < 8; i++) begin
      tick();
      bus.M = b[i];
      #1;
      e = {1'b0, 1'b0, b[i], b[i] & (i == 7), 1'b0, 1'b1};
      chk($sformatf("%s_add%0d", tg, i),
          {bus.LoadB, bus.Clr_A, bus.Add, bus.Sub, bus.Shift, bus.Busy}, e);
      tick();
      chk($sformatf("%s_shift%0d", tg, i),
          {bus.Add, bus.Sub, bus.Shift, bus.Busy, bus.Done}, 5'b00110);
    end
    tick();
    chk({tg, "_done"}, {bus.Busy, bus.Done, bus.Add, bus.Shift}, 4'b0100);
    bus.M = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [6:0] acc;
    int dn;
    int cl;

    Reset            = 1'b0;
    bus.Run          = 1'b0;
    bus.ClearA_LoadB = 1'b0;
    bus.M            = 1'b1;
    repeat (3) tick();
    chk("rst_outs", outs, 0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));

    bus.Run          = 1'b1;
    bus.ClearA_LoadB = 1'b1;
    bus.M            = 1'b0;
    tick();
    Reset = 1'b1;
    acc = '0;
    repeat (20) begin tick(); acc |= outs; end
    chk("no_spurious", acc, 0);

    // Three-cycle glitch must not reach the debounced level.
    bus.Run = 1'b0;
    repeat (3) tick();
    bus.Run = 1'b1;
    acc = '0;
    repeat (15) begin tick(); acc |= outs; end
    chk("glitch", acc, 0);

    bus.M   = 1'b1;
    bus.Run = 1'b0;
    wait_for("run_lat", 0, 7);
    do_mult(8'hFF, "m1");

    dn = 0;
    cl = 0;
    repeat (100) begin
      tick();
      dn += int'(bus.Done);
      cl += int'(bus.Clr_A | bus.Busy);
    end
    chk("hold_done", dn, 100);
    chk("hold_noretrig", cl, 0);
    bus.Run = 1'b1;
    wait_for("hold_exit", 2, 7);
    chk("idle_after_m1", outs, 0);

    // Run released and LoadB pressed mid-multiply: neither aborts nor queues.
    repeat (5) tick();
    bus.Run = 1'b0;
    wait_for("run2_lat", 0, 7);
    bus.Run          = 1'b1;
    bus.ClearA_LoadB = 1'b0;
    do_mult(8'h03, "m2");
    tick();
    chk("hold_1cyc", {bus.Done, bus.Busy}, 0);
    acc = '0;
    repeat (10) begin tick(); acc |= outs; end
    chk("loadb_not_queued", acc, 0);
    bus.ClearA_LoadB = 1'b1;
    repeat (10) tick();

    bus.ClearA_LoadB = 1'b0;
    wait_for("loadb_lat", 1, 6);
    chk("loadb_only", {bus.Clr_A, bus.Busy}, 0);
    tick();
    chk("loadb_pulse", bus.LoadB, 0);
    bus.ClearA_LoadB = 1'b1;
    repeat (10) tick();

    bus.Run          = 1'b0;
    bus.ClearA_LoadB = 1'b0;
    wait_for("both_lat", 1, 6);
    acc = '0;
    repeat (15) begin tick(); acc |= outs; end
    chk("both_loadb_wins", acc, 0);
    bus.Run          = 1'b1;
    bus.ClearA_LoadB = 1'b1;
    repeat (10) tick();

    bus.M   = 1'b1;
    bus.Run = 1'b0;
    wait_for("run3_lat", 0, 7);
    repeat (7) tick();
    chk("it3_add", {bus.Add, bus.Shift}, 2'b10);
    chk("it3_iter", 32'(dut.iter_q), 3);
    Reset = 1'b0;
    #1;
    chk("rst_mid_outs", outs, 0);
    chk("rst_mid_state", 32'(dut.state_q), 32'(IDLE));
    bus.Run = 1'b1;
    repeat (2) tick();
    Reset = 1'b1;
    acc = '0;
    repeat (20) begin tick(); acc |= outs; end
    chk("no_resume", acc, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
